mb32_mover: RTL and testbench
=============================

// Module: mb32_mover
// PURPOSE
//  Bus-master block engine for the mb32_io memory bus; initiator counterpart of spram32_32k.
//  Executes Forth-style FILL and CMOVE (word copy) on the 32K x 32 single-port RAM.
//  It drives ai/we/vi/bmsk and samples vo, freeing the core from per-word loops.
//  Sits between the eForth core's command registers and the memory bus master port.
// PARAMETERS
//  ASZ   15   word address width (32K words); all address arithmetic is modulo 2**ASZ
//  DSZ   32   data width
// PORTS
//  clk     in   1     system clock, rising edge
//  rst_n   in   1     asynchronous active-low reset
//  start   in   1     command strobe, accepted only in IDLE
//  op      in   1     0 = FILL, 1 = MOVE
//  src     in   ASZ   MOVE source word address
//  dst     in   ASZ   destination word address
//  len     in   ASZ+1 word count, 0..2**ASZ
//  val     in   DSZ   FILL value
//  busy    out  1     high from the cycle after an accepted start until done
//  done    out  1     one-cycle pulse at completion
//  b32     mb32_io.master  bus: ai[ASZ], we, vi[DSZ], bmsk[4] out; vo[DSZ] in
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, ai=0, we=0, vi=0, bmsk=4'b1111.
//  Bus rules: spram read data is valid on vo one clk after ai is presented with we=0.
//  A write commits at the clk edge where we=1. bmsk is held at 4'b1111; no partial words.
//  start in IDLE latches op/src/dst/len/val; start while busy is ignored.
//  States:
//   IDLE: we=0. On start with len==0, go to DONE. On start with len>0, go to FILL or RD per op.
//   FILL: ai=dst, vi=val, we=1 each cycle. dst++, cnt--. When cnt reaches 0, go to DONE.
//         Throughput is 1 word/clk.
//   RD:   ai=src, we=0. Go to WR.
//   WR:   ai=dst, vi=vo, we=1. src++, dst++, cnt--. If cnt==0, go to DONE, else go to RD.
//         Throughput is 2 clk/word.
//   DONE: we=0, done=1 for one cycle, busy=0. Go to IDLE.
//  Latency: FILL of N words takes N+2 clk from start to done; MOVE of N words takes 2N+2.
//  Address wrap: 'h7fff+1 -> 0, silently. len=2**ASZ touches every word exactly once.
//  Overlap (no macro): always ascending. dst in (src, src+len) smears src data forward.
//    This is CMOVE semantics.
//  src==dst: legal; memory is unchanged.
//  Async reset mid-operation: immediate return to IDLE, we=0. No done pulse.
//    Words already written stay written.
//  Simultaneous start and done cycle: start is ignored (state is not IDLE).
// CONFIGURATION
//  MB32_MOVER_OVERLAP_EN defined: MOVE with dst>src and dst<src+len runs descending.
//    Start addresses become src+len-1 and dst+len-1, both decrementing mod 2**ASZ.
//    Result is a non-destructive copy (CMOVE> semantics). Timing is unchanged.
//  Undefined: ascending only, as above.
// STRUCTURE
//  mb32_pkg holds: ASZ/DSZ localparams, typedef logic [ASZ-1:0] addr_t,
//    enum {OP_FILL, OP_MOVE} op_e, and the FSM state enum mover_st_e.
//  Sub-module mb32_agen: loadable up/down ASZ-bit address counter, instanced for src and dst.
//  The down direction is used only under MB32_MOVER_OVERLAP_EN.
// TESTING (bench instantiates mb32_mover + spram32_32k on one mb32_io)
//  1. FILL dst=0 len=15 val='hdeadbeef
//     -> words 0..14 read back 'hdeadbeef, word 15 untouched; done at clk 17 after start.
//  2. Preload word i = i*3 at 'h10..'h17; MOVE src='h10 dst='h100 len=8
//     -> 'h100+i = i*3; done at clk 18.
//  3. FILL dst='h7ffe len=4 val=5 -> words 'h7ffe, 'h7fff, 0, 1 = 5; word 2 untouched.
//  4. Overlap: preload 'h20..'h23 = 1,2,3,4; MOVE src='h20 dst='h21 len=4
//     -> without macro 'h21..'h24 = 1,1,1,1; with macro = 1,2,3,4.
//  5. len=0 -> done pulse 2 clk after start, we never asserted.
//     start pulsed while busy -> ignored; original op completes intact.
//  6. Assert rst_n=0 mid-MOVE (after 3 words)
//     -> busy=0, we=0 same cycle; no done; the next FILL runs normally.

Source files
------------

// File: rtl/mb32_pkg.sv
// Shared types for the mb32 bus block mover: widths, address/count types, op and FSM enums.
package mb32_pkg;
  localparam int ASZ = 15;
  localparam int DSZ = 32;

  typedef logic [ASZ-1:0] addr_t;
  typedef logic [ASZ:0]   cnt_t;
  typedef logic [DSZ-1:0] data_t;

  typedef enum logic {OP_FILL = 1'b0, OP_MOVE = 1'b1} op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_RD,
    ST_WR,
    ST_DONE
  } mover_st_e;

  // Last word of a block starting at base; len of 2**ASZ wraps back to base-1.
  function automatic addr_t addr_end(addr_t base, cnt_t n);
    return base + addr_t'(n) - addr_t'(1);
  endfunction
endpackage

// File: rtl/mb32_io.sv
// mb32 memory bus between an initiator (master) and the single-port RAM (slave).
interface mb32_io;
  import mb32_pkg::*;
  addr_t      ai;
  logic       we;
  data_t      vi;
  data_t      vo;
  logic [3:0] bmsk;

  modport master (output ai, output we, output vi, output bmsk, input vo);
  modport slave  (input ai, input we, input vi, input bmsk, output vo);
endinterface

// File: rtl/mb32_agen.sv
// Loadable up/down word-address counter; wraps modulo 2**ASZ.
module mb32_agen
  import mb32_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  addr_t ld_val,
  input  logic  en,
  input  logic  dn,
  output addr_t q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= ld_val;
    else if (en)   q <= dn ? q - addr_t'(1) : q + addr_t'(1);
  end
endmodule

// File: rtl/mb32_mover.sv
// FILL / CMOVE block engine mastering the mb32 bus.
// Define MB32_MOVER_OVERLAP_EN to run forward-overlapping MOVEs descending (CMOVE>).
module mb32_mover
  import mb32_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           op,
  input  logic [ASZ-1:0] src,
  input  logic [ASZ-1:0] dst,
  input  logic [ASZ:0]   len,
  input  logic [DSZ-1:0] val,
  output logic           busy,
  output logic           done,
  mb32_io.master         b32
);
  mover_st_e st, st_nx;
  cnt_t      cnt_q;
  data_t     val_q;
  addr_t     src_a, dst_a, src_ld, dst_ld;
  logic      accept, src_en, dst_en, cnt_dec, desc_nx, desc_q;

  assign accept = (st == ST_IDLE) && start;

`ifdef MB32_MOVER_OVERLAP_EN
  // Forward overlap measured modulo the address space: dst lies inside (src, src+len).
  addr_t gap;
  assign gap     = dst - src;
  assign desc_nx = (op_e'(op) == OP_MOVE) && (gap != '0) && ({1'b0, gap} < len);
  assign src_ld  = desc_nx ? addr_end(src, len) : src;
  assign dst_ld  = desc_nx ? addr_end(dst, len) : dst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      desc_q <= 1'b0;
    else if (accept) desc_q <= desc_nx;
  end
`else
  assign desc_nx = 1'b0;
  assign desc_q  = desc_nx;
  assign src_ld  = src;
  assign dst_ld  = dst;
`endif

  mb32_agen u_src (
    .clk(clk), .rst_n(rst_n), .load(accept), .ld_val(src_ld),
    .en(src_en), .dn(desc_q), .q(src_a)
  );

  mb32_agen u_dst (
    .clk(clk), .rst_n(rst_n), .load(accept), .ld_val(dst_ld),
    .en(dst_en), .dn(desc_q), .q(dst_a)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= ST_IDLE;
      cnt_q <= '0;
      val_q <= '0;
    end else begin
      st <= st_nx;
      if (accept) begin
        cnt_q <= len;
        val_q <= val;
      end else if (cnt_dec) begin
        cnt_q <= cnt_q - cnt_t'(1);
      end
    end
  end

  assign b32.bmsk = 4'b1111;

  always_comb begin
    st_nx   = st;
    busy    = 1'b0;
    done    = 1'b0;
    b32.ai  = '0;
    b32.we  = 1'b0;
    b32.vi  = '0;
    src_en  = 1'b0;
    dst_en  = 1'b0;
    cnt_dec = 1'b0;
    case (st)
      ST_IDLE: begin
        if (start) begin
          if (len == '0)                    st_nx = ST_DONE;
          else if (op_e'(op) == OP_MOVE)    st_nx = ST_RD;
          else                              st_nx = ST_FILL;
        end
      end
      ST_FILL: begin
        busy    = 1'b1;
        b32.ai  = dst_a;
        b32.vi  = val_q;
        b32.we  = 1'b1;
        dst_en  = 1'b1;
        cnt_dec = 1'b1;
        if (cnt_q == cnt_t'(1)) st_nx = ST_DONE;
      end
      ST_RD: begin
        busy   = 1'b1;
        b32.ai = src_a;
        st_nx  = ST_WR;
      end
      ST_WR: begin
        // RAM read data for src_a arrives on vo this cycle and is written straight back.
        busy    = 1'b1;
        b32.ai  = dst_a;
        b32.vi  = b32.vo;
        b32.we  = 1'b1;
        src_en  = 1'b1;
        dst_en  = 1'b1;
        cnt_dec = 1'b1;
        st_nx   = (cnt_q == cnt_t'(1)) ? ST_DONE : ST_RD;
      end
      ST_DONE: begin
        done  = 1'b1;
        st_nx = ST_IDLE;
      end
      default: st_nx = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_mb32_mover.sv
// Self-checking bench: mb32_mover driving a behavioural 32K x 32 RAM, checked against a word-level model.
module tb_mb32_mover;
  import mb32_pkg::*;
  localparam int MW = 1 << ASZ;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           op = 1'b0;
  logic [ASZ-1:0] src = '0;
  logic [ASZ-1:0] dst = '0;
  logic [ASZ:0]   len = '0;
  logic [DSZ-1:0] val = '0;
  logic           busy, done;

  mb32_io b32();

  mb32_mover dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src(src), .dst(dst),
    .len(len), .val(val), .busy(busy), .done(done), .b32(b32)
  );

  always #5 clk = ~clk;

  // RAM on the bus plus a side port the bench uses for preloading while the mover is idle.
  logic [DSZ-1:0] mem     [MW];
  logic [DSZ-1:0] ref_mem [MW];
  logic           pre_we = 1'b0;
  logic [ASZ-1:0] pre_a = '0;
  logic [DSZ-1:0] pre_d = '0;

  always @(posedge clk) begin
    if (b32.we)      mem[b32.ai] <= b32.vi;
    else if (pre_we) mem[pre_a]  <= pre_d;
    b32.vo <= mem[b32.ai];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_mem(string tag);
    int bad = 0;
    int first = 0;
    for (int i = 0; i < MW; i++)
      if (mem[i] !== ref_mem[i]) begin
        if (bad == 0) first = i;
        bad++;
      end
    checks++;
    assert (bad === 0) else begin
      errors++;
      $error("FAIL %s mem: %0d words differ, first @%0h observed %0h expected %0h",
             tag, bad, first, mem[first], ref_mem[first]);
    end
  endtask

  task automatic preload(int a, logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_a = addr_t'(a); pre_d = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
    ref_mem[a % MW] = d;
  endtask

  task automatic model_fill(int d, int n, logic [31:0] v);
    for (int i = 0; i < n; i++) ref_mem[(d + i) % MW] = v;
  endtask

  // Without the overlap option words are copied one at a time in ascending order, so a
  // forward overlap re-reads words already written; with it the result is a clean copy.
  task automatic model_move(int s, int d, int n);
    logic [31:0] snap [$];
`ifdef MB32_MOVER_OVERLAP_EN
    for (int i = 0; i < n; i++) snap.push_back(ref_mem[(s + i) % MW]);
    for (int i = 0; i < n; i++) ref_mem[(d + i) % MW] = snap[i];
`else
    snap = {};
    for (int i = 0; i < n; i++) ref_mem[(d + i) % MW] = ref_mem[(s + i) % MW];
`endif
  endtask

  // Cycle numbering: the cycle in which start is presented is cycle 1.
  task automatic run_op(string tag, bit is_mv, int s, int d, int n, logic [31:0] v, bit spur);
    int cyc, dcyc, wes, lim;
    @(negedge clk);
    op = is_mv; src = addr_t'(s); dst = addr_t'(d); len = cnt_t'(n); val = v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 2; dcyc = -1; wes = 0; lim = 2 * n + 50;
    if (n > 0) chk({tag, " busy"}, busy, 1);
    while (cyc < lim) begin
      if (done) begin dcyc = cyc; break; end
      if (b32.we) wes++;
      if (spur && cyc == 3) begin
        start = 1'b1; op = ~op; src = src + 7; dst = dst + 9; len = 3; val = ~val;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, " done_cyc"}, dcyc, is_mv ? 2 * n + 2 : n + 2);
    chk({tag, " we_count"}, wes, n);
    chk({tag, " busy_at_done"}, busy, 0);
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, done, 0);
    if (is_mv) model_move(s, d, n);
    else       model_fill(d, n, v);
    check_mem(tag);
  endtask

  initial begin
    logic [31:0] rv;
    int rs, rd, rn, base;
    bit rop;

    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst we", b32.we, 0);
    chk("rst ai", b32.ai, 0);
    chk("rst vi", b32.vi, 0);
    chk("rst bmsk", b32.bmsk, 4'b1111);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Whole-memory fill: every word exactly once, wrapping through 0.
    rv = $urandom;
    run_op("full_fill", 1'b0, 'h1234, 'h1234, MW, rv, 1'b0);

    // 1. FILL 15 words at 0
    preload(15, 'h0f0f0f0f);
    run_op("fill15", 1'b0, 0, 0, 15, 'hdeadbeef, 1'b0);
    chk("fill15 w0", mem[0], 'hdeadbeef);
    chk("fill15 w14", mem[14], 'hdeadbeef);
    chk("fill15 w15", mem[15], 'h0f0f0f0f);

    // 2. MOVE 8 words
    for (int i = 0; i < 8; i++) preload('h10 + i, i * 3);
    run_op("move8", 1'b1, 'h10, 'h100, 8, 0, 1'b0);
    for (int i = 0; i < 8; i++) chk($sformatf("move8 w%0d", i), mem['h100 + i], i * 3);

    // 3. FILL across the top of memory
    preload(2, 'h2222);
    run_op("fill_wrap", 1'b0, 0, 'h7ffe, 4, 5, 1'b0);
    chk("wrap 7ffe", mem['h7ffe], 5);
    chk("wrap 7fff", mem['h7fff], 5);
    chk("wrap 0", mem[0], 5);
    chk("wrap 1", mem[1], 5);
    chk("wrap 2", mem[2], 'h2222);

    // 4. forward-overlapping MOVE
    for (int i = 0; i < 4; i++) preload('h20 + i, i + 1);
    run_op("overlap", 1'b1, 'h20, 'h21, 4, 0, 1'b0);
    for (int i = 0; i < 4; i++)
`ifdef MB32_MOVER_OVERLAP_EN
      chk($sformatf("overlap w%0d", i), mem['h21 + i], i + 1);
`else
      chk($sformatf("overlap w%0d", i), mem['h21 + i], 1);
`endif

    // 5. zero length, start while busy, src==dst
    run_op("len0_fill", 1'b0, 0, 'h300, 0, 'h77, 1'b0);
    run_op("len0_move", 1'b1, 'h10, 'h300, 0, 0, 1'b0);
    run_op("spur_fill", 1'b0, 0, 'h200, 10, 'hcafef00d, 1'b1);
    run_op("spur_move", 1'b1, 'h10, 'h210, 6, 0, 1'b1);
    run_op("same_addr", 1'b1, 'h50, 'h50, 5, 0, 1'b0);

    // 6. async reset after three words of a MOVE
    for (int i = 0; i < 8; i++) preload('h300 + i, 'ha0 + i);
    @(negedge clk);
    op = 1'b1; src = 'h300; dst = 'h400; len = 8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("mid busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort we", b32.we, 0);
    chk("abort done", done, 0);
    for (int i = 0; i < 3; i++) ref_mem['h400 + i] = ref_mem['h300 + i];
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort no_done", done, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_mem("abort partial");
    run_op("after_rst", 1'b0, 0, 'h404, 6, 'h5a5a5a5a, 1'b0);

    // Randomised FILL/MOVE mix, including windows that straddle the wrap point.
    for (int k = 0; k < 24; k++) begin
      rop  = 1'($urandom_range(0, 1));
      base = ($urandom_range(0, 1) == 1) ? 'h7fc0 : 'h40;
      rs   = (base + $urandom_range(0, 63)) % MW;
      rd   = (base + $urandom_range(0, 63)) % MW;
      rn   = $urandom_range(0, 40);
      rv   = $urandom;
      run_op($sformatf("rand%0d", k), rop, rs, rd, rn, rv, rn >= 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
